// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC register, instruction-memory handshake and IF/ID pipeline register.
// A hold buffer keeps a word that arrives while ID is stalled or flushed, so no fetched word is lost.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        pcsrc_d_i,
  input  logic [31:0] pcbranch_d_i,
  input  logic        jump_d_i,
  input  logic [31:0] pcjump_d_i,
  output logic [31:0] pc_f_o,
  output logic [31:0] instr_d_o,
  output logic [31:0] pcplus4_d_o,
  output logic        valid_d_o
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HELD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        ack;
  logic        redirect;
  logic [31:0] target;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;

    ack      = imem_ack_i && (state_q != S_HELD);
    redirect = jump_d_i || pcsrc_d_i;
    target   = (jump_d_i ? pcjump_d_i : pcbranch_d_i) & ~32'h3;

    if (redirect) begin
      pc_d    = target;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (state_q == S_HELD || ack) begin
        state_d = S_REQ;
      end else begin
        state_d = S_DISCARD;
        // Keep presenting the address of the request still in flight.
        if (state_q == S_REQ) addr_d = pc_q;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (ack) begin
            pc_d = pc_q + 32'd4;
            if (flush_d_i || stall_d_i) begin
              hold_instr_d = imem_rdata_i;
              hold_pc4_d   = pc_q + 32'd4;
              state_d      = S_HELD;
              if (flush_d_i) begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
              end
            end else begin
              instr_d = imem_rdata_i;
              pc4_d   = pc_q + 32'd4;
              valid_d = 1'b1;
            end
          end else if (flush_d_i || !stall_d_i) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
          end
        end
        S_HELD: begin
          if (flush_d_i) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
          end else if (!stall_d_i) begin
            instr_d = hold_instr_q;
            pc4_d   = hold_pc4_q;
            valid_d = 1'b1;
            state_d = S_REQ;
          end
        end
        default: begin
          if (ack) state_d = S_REQ;
          if (flush_d_i || !stall_d_i) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  assign imem_req_o  = rst_n_i && (state_q != S_HELD);
  assign imem_addr_o = (state_q == S_DISCARD) ? addr_q : pc_q;
  assign pc_f_o      = pc_q;
  assign instr_d_o   = instr_q;
  assign pcplus4_d_o = pc4_q;
  assign valid_d_o   = valid_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage; the memory model returns the fetch address as the word.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_d, flush_d, pcsrc_d, jump_d;
  logic [31:0] pcbranch_d, pcjump_d;
  logic [31:0] pc_f, instr_d, pcplus4_d;
  logic        valid_d;

  int total = 0;
  int bad   = 0;

  mips_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .stall_d_i(stall_d), .flush_d_i(flush_d),
    .pcsrc_d_i(pcsrc_d), .pcbranch_d_i(pcbranch_d),
    .jump_d_i(jump_d), .pcjump_d_i(pcjump_d),
    .pc_f_o(pc_f), .instr_d_o(instr_d), .pcplus4_d_o(pcplus4_d), .valid_d_o(valid_d)
  );

  always #5 clk = ~clk;

  // One clock: memory answers with the word at the presented address when ack is set.
  task automatic cycle(input logic ack);
    imem_ack   = ack;
    imem_rdata = imem_addr;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
  endtask

  task automatic clear_ctrl();
    stall_d = 0; flush_d = 0; pcsrc_d = 0; jump_d = 0;
    pcbranch_d = 32'h0; pcjump_d = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ctrl();
    imem_ack = 0; imem_rdata = 32'h0;
    @(posedge clk); #1;
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_f, 32'h0); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr_d); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1);
      total++;
      if (pc_f !== 32'(4*k) || instr_d !== 32'(4*(k-1)) || pcplus4_d !== 32'(4*k) || valid_d !== 1'b1) begin
        bad++; $display("FAIL zero_wait_%0d got pc=%h instr=%h pc4=%h v=%b exp pc=%h instr=%h pc4=%h v=1",
                        k, pc_f, instr_d, pcplus4_d, valid_d, 32'(4*k), 32'(4*(k-1)), 32'(4*k));
      end
    end
  endtask

  task automatic test_wait();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || valid_d !== 1'b0 || instr_d !== 32'h0) begin
        bad++; $display("FAIL wait_%0d got req=%b addr=%h v=%b instr=%h exp 1/00000010/0/0",
                        k, imem_req, imem_addr, valid_d, instr_d);
      end
    end
    cycle(1'b1);
    total++;
    if (instr_d !== 32'h10 || pcplus4_d !== 32'h14 || valid_d !== 1'b1 || pc_f !== 32'h14) begin
      bad++; $display("FAIL wait_ack got instr=%h pc4=%h v=%b pc=%h exp 10/14/1/14", instr_d, pcplus4_d, valid_d, pc_f);
    end
  endtask

  task automatic test_stall();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    stall_d = 1'b1;
    cycle(1'b1);
    total++;
    if (instr_d !== 32'h4 || valid_d !== 1'b1 || pc_f !== 32'hC || imem_req !== 1'b0) begin
      bad++; $display("FAIL stall_ack got instr=%h v=%b pc=%h req=%b exp 4/1/c/0", instr_d, valid_d, pc_f, imem_req);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0);
      total++;
      if (instr_d !== 32'h4 || pcplus4_d !== 32'h8 || valid_d !== 1'b1) begin
        bad++; $display("FAIL stall_hold_%0d got instr=%h pc4=%h v=%b exp 4/8/1", k, instr_d, pcplus4_d, valid_d);
      end
    end
    stall_d = 1'b0;
    cycle(1'b0);
    total++;
    if (instr_d !== 32'h8 || pcplus4_d !== 32'hC || valid_d !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      bad++; $display("FAIL stall_release got instr=%h pc4=%h v=%b req=%b addr=%h exp 8/c/1/1/c",
                      instr_d, pcplus4_d, valid_d, imem_req, imem_addr);
    end
    cycle(1'b1);
    total++;
    if (instr_d !== 32'hC || valid_d !== 1'b1 || pc_f !== 32'h10) begin
      bad++; $display("FAIL stall_next got instr=%h v=%b pc=%h exp c/1/10", instr_d, valid_d, pc_f);
    end
  endtask

  task automatic test_branch();
    cycle(1'b0);
    pcsrc_d = 1'b1; pcbranch_d = 32'h40;
    cycle(1'b0);
    clear_ctrl();
    total++;
    if (pc_f !== 32'h40 || valid_d !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      bad++; $display("FAIL branch_discard got pc=%h v=%b addr=%h req=%b exp 40/0/10/1", pc_f, valid_d, imem_addr, imem_req);
    end
    cycle(1'b1);
    total++;
    if (valid_d !== 1'b0 || instr_d !== 32'h0 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL branch_drop got v=%b instr=%h addr=%h exp 0/0/40", valid_d, instr_d, imem_addr);
    end
    cycle(1'b1);
    total++;
    if (instr_d !== 32'h40 || valid_d !== 1'b1 || pc_f !== 32'h44) begin
      bad++; $display("FAIL branch_target got instr=%h v=%b pc=%h exp 40/1/44", instr_d, valid_d, pc_f);
    end
  endtask

  task automatic test_jump_priority();
    jump_d = 1'b1; pcjump_d = 32'h83; pcsrc_d = 1'b1; pcbranch_d = 32'h40;
    cycle(1'b1);
    clear_ctrl();
    total++;
    if (pc_f !== 32'h80 || valid_d !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1) begin
      bad++; $display("FAIL jump_prio got pc=%h v=%b addr=%h req=%b exp 80/0/80/1", pc_f, valid_d, imem_addr, imem_req);
    end
    cycle(1'b1);
    total++;
    if (instr_d !== 32'h80 || pcplus4_d !== 32'h84 || pc_f !== 32'h84) begin
      bad++; $display("FAIL jump_fetch got instr=%h pc4=%h pc=%h exp 80/84/84", instr_d, pcplus4_d, pc_f);
    end
  endtask

  task automatic test_flush();
    flush_d = 1'b1;
    cycle(1'b1);
    clear_ctrl();
    total++;
    if (valid_d !== 1'b0 || pc_f !== 32'h88 || imem_req !== 1'b0) begin
      bad++; $display("FAIL flush_ack got v=%b pc=%h req=%b exp 0/88/0", valid_d, pc_f, imem_req);
    end
    cycle(1'b0);
    total++;
    if (instr_d !== 32'h84 || valid_d !== 1'b1 || imem_addr !== 32'h88 || imem_req !== 1'b1) begin
      bad++; $display("FAIL flush_release got instr=%h v=%b addr=%h req=%b exp 84/1/88/1", instr_d, valid_d, imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0);
    imem_ack = 1'b1; imem_rdata = imem_addr;
    #2; rst_n = 1'b0; #1;
    total++;
    if (pc_f !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL reset_mid got pc=%h v=%b instr=%h req=%b exp 0/0/0/0", pc_f, valid_d, instr_d, imem_req);
    end
    @(posedge clk); #1;
    total++;
    if (pc_f !== 32'h0 || valid_d !== 1'b0) begin
      bad++; $display("FAIL reset_ack_ignored got pc=%h v=%b exp 0/0", pc_f, valid_d);
    end
    imem_ack = 1'b0;
    rst_n = 1'b1; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_restart got req=%b addr=%h exp 1/0", imem_req, imem_addr);
    end
    cycle(1'b1);
    total++;
    if (instr_d !== 32'h0 || valid_d !== 1'b1 || pc_f !== 32'h4) begin
      bad++; $display("FAIL reset_first got instr=%h v=%b pc=%h exp 0/1/4", instr_d, valid_d, pc_f);
    end
  endtask

  task automatic test_wrap();
    stall_d = 1'b1; jump_d = 1'b1; pcjump_d = 32'hFFFF_FFFC;
    cycle(1'b1);
    clear_ctrl();
    total++;
    if (pc_f !== 32'hFFFF_FFFC || valid_d !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL jump_over_stall got pc=%h v=%b req=%b exp fffffffc/0/1", pc_f, valid_d, imem_req);
    end
    cycle(1'b1);
    total++;
    if (pc_f !== 32'h0 || instr_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0 || valid_d !== 1'b1) begin
      bad++; $display("FAIL wrap got pc=%h instr=%h pc4=%h v=%b exp 0/fffffffc/0/1", pc_f, instr_d, pcplus4_d, valid_d);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait();
    test_stall();
    test_branch();
    test_jump_priority();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 imem_req  output  1  instruction memory request.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall_d  input  1  ID stage cannot accept a new instruction.
REQ-009 flush_d  input  1  insert bubble into IF/ID this cycle.
REQ-010 pcsrc_d  input  1  branch taken, resolved in ID.
REQ-011 pcbranch_d  input  32  branch target.
REQ-012 jump_d  input  1  jump, resolved in ID.
REQ-013 pcjump_d  input  32  jump target.
REQ-014 pc_f  output  32  current fetch PC.
REQ-015 instr_d, pcplus4_d  output  32 each  IF/ID register contents.
REQ-016 valid_d  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states: S_REQ (request outstanding), S_HELD (word captured, ID stalled), S_DISCARD (redirected while request outstanding).
REQ-018 imem_req = 1 in S_REQ and S_DISCARD while reset is deasserted; 0 in S_HELD.
REQ-019 imem_addr = pc_f in S_REQ; stays at the old address in S_DISCARD; stable from assertion of imem_req until imem_ack.
REQ-020 imem_ack may arrive in the same cycle as imem_req (zero-wait) or any later cycle.
REQ-021 Priority per cycle: reset > redirect (jump_d over pcsrc_d) > flush_d > stall_d > normal.
REQ-022 S_REQ, ack, no redirect, stall_d=0: IF/ID <= {imem_rdata, pc_f+4, valid=1}; pc_f <= pc_f+4; stay S_REQ.
REQ-023 S_REQ, ack, stall_d=1: word and pc_f+4 into hold buffer; IF/ID unchanged; pc_f <= pc_f+4; go S_HELD.
REQ-024 S_REQ, no ack, stall_d=0: IF/ID <= bubble (instr 0, pcplus4 0, valid 0).
REQ-025 stall_d=1 without redirect: IF/ID holds its contents.
REQ-026 S_HELD, stall_d=0: hold buffer -> IF/ID with valid=1; go S_REQ.
REQ-027 Redirect (jump_d or pcsrc_d): pc_f <= target with bits [1:0] forced 0; IF/ID <= bubble; hold buffer invalidated; overrides stall_d.
REQ-028 Redirect in S_REQ with no ack in that cycle: go S_DISCARD; returning word is dropped on its ack, then S_REQ at the new pc_f.
REQ-029 Redirect coinciding with ack: word dropped; go S_REQ at target; pc_f+4 not applied.
REQ-030 Redirect in S_DISCARD: pc_f updated to the newest target; remain S_DISCARD.
REQ-031 flush_d without redirect: IF/ID <= bubble; any word accepted this cycle goes to the hold buffer (S_HELD) rather than being lost.
REQ-032 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-033 Each fetched word reaches IF/ID exactly once unless dropped by redirect; no duplication or reordering.

Reset
REQ-034 reset=0 asynchronously forces pc_f=RESET_PC, instr_d=0, pcplus4_d=0, valid_d=0, hold buffer invalid, state S_REQ, imem_req=0.
REQ-035 First request issues at address RESET_PC in the first cycle after reset deasserts.
REQ-036 Reset mid-request discards the outstanding transaction; an ack arriving during reset is ignored.

Verification
REQ-037 Zero-wait memory (ack every cycle), memory word = address -> pc_f 0,4,8,...; instr_d = 0,4,8 one cycle later; pcplus4_d = instr_d+4; valid_d=1.
REQ-038 Ack 2 cycles after request -> imem_addr stable; valid_d=0, instr_d=0 during the wait; instr appears the cycle after ack.
REQ-039 stall_d=1 for 3 cycles across an ack at addr 0x8 -> IF/ID holds 0x4's word; 0x8's word appears on release; next fetch is 0xC; no loss or duplication.
REQ-040 pcsrc_d=1, pcbranch_d=0x40 while request at 0x10 outstanding -> 0x10 word dropped, valid_d=0, next imem_addr=0x40.
REQ-041 jump_d=1 (pcjump_d=0x80) with pcsrc_d=1 (pcbranch_d=0x40) in the same cycle -> pc_f=0x80.
REQ-042 reset pulsed low mid-wait -> outputs immediately at reset values; after release, first imem_addr=RESET_PC; PC at 0xFFFF_FFFC wraps to 0x0.
